// File: rtl/placement_run_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | placement_run_sequencer_pkg                                        |
// | Shared state encoding and seed-advance function for the sequencer. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package placement_run_sequencer_pkg;

   localparam int c_SEED_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RESET  = 3'd1,
      S_LOAD   = 3'd2,
      S_RUN    = 3'd3,
      S_REPORT = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   // Standard 13/17/5 xorshift; never maps a non-zero seed to zero.
   function automatic logic [c_SEED_WIDTH-1:0] xorshift32(input logic [c_SEED_WIDTH-1:0] i_x);
      logic [c_SEED_WIDTH-1:0] w_x;
      w_x = i_x;
      w_x = w_x ^ (w_x << 13);
      w_x = w_x ^ (w_x >> 17);
      w_x = w_x ^ (w_x << 5);
      return w_x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/placement_run_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | placement_run_sequencer_if                                         |
// | Config, engine and result channels of the run sequencer.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface placement_run_sequencer_if #(
   parameter int SEED_WIDTH = 32,
   parameter int EDGE_WIDTH = 8,
   parameter int COST_WIDTH = 16,
   parameter int RUNS_WIDTH = 8,
   parameter int CYC_WIDTH  = 24
) ();

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [SEED_WIDTH-1:0] cfg_seed;
   logic [EDGE_WIDTH-1:0] cfg_n_edge;
   logic [RUNS_WIDTH-1:0] cfg_n_runs;

   logic                  pl_rst;
   logic                  pl_loadseed;
   logic [SEED_WIDTH-1:0] pl_seed;
   logic                  pl_start;
   logic [EDGE_WIDTH-1:0] pl_n_edge;
   logic                  pl_done;
   logic [COST_WIDTH-1:0] pl_cost;

   logic                  res_valid;
   logic                  res_ready;
   logic [RUNS_WIDTH-1:0] res_run;
   logic [SEED_WIDTH-1:0] res_seed;
   logic [COST_WIDTH-1:0] res_cost;
   logic [CYC_WIDTH-1:0]  res_cycles;
   logic                  res_timeout;

   logic [COST_WIDTH-1:0] best_cost;
   logic [SEED_WIDTH-1:0] best_seed;
   logic                  busy;
   logic                  finished;

   modport master (
      input  cfg_valid, cfg_seed, cfg_n_edge, cfg_n_runs,
      input  pl_done, pl_cost,
      input  res_ready,
      output cfg_ready,
      output pl_rst, pl_loadseed, pl_seed, pl_start, pl_n_edge,
      output res_valid, res_run, res_seed, res_cost, res_cycles, res_timeout,
      output best_cost, best_seed, busy, finished
   );

   modport slave (
      output cfg_valid, cfg_seed, cfg_n_edge, cfg_n_runs,
      output pl_done, pl_cost,
      output res_ready,
      input  cfg_ready,
      input  pl_rst, pl_loadseed, pl_seed, pl_start, pl_n_edge,
      input  res_valid, res_run, res_seed, res_cost, res_cycles, res_timeout,
      input  best_cost, best_seed, busy, finished
   );

endinterface
`default_nettype wire

// File: rtl/placement_run_sequencer_seed_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | placement_run_sequencer_seed_gen                                   |
// | Per-run seed register: load with zero-fix, xorshift32 advance.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module placement_run_sequencer_seed_gen
   import placement_run_sequencer_pkg::*;
(
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    i_load,
   input  wire logic                    i_advance,
   input  wire logic [c_SEED_WIDTH-1:0] i_seed,
   output      logic [c_SEED_WIDTH-1:0] o_seed
);

   localparam logic [c_SEED_WIDTH-1:0] c_SEED_ONE = c_SEED_WIDTH'(1);

   logic [c_SEED_WIDTH-1:0] r_seed;

   // Zero is a fixed point of xorshift, so a zero seed is promoted to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seed <= '0;
      end else if (i_load) begin
         r_seed <= (i_seed == '0) ? c_SEED_ONE : i_seed;
      end else if (i_advance) begin
         r_seed <= xorshift32(r_seed);
      end
   end

   assign o_seed = r_seed;

endmodule
`default_nettype wire

// File: rtl/placement_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | placement_run_sequencer                                            |
// | Runs the placement engine N times from advancing seeds, tracks best|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module placement_run_sequencer
   import placement_run_sequencer_pkg::*;
#(
   parameter int SEED_WIDTH = 32,
   parameter int EDGE_WIDTH = 8,
   parameter int COST_WIDTH = 16,
   parameter int RUNS_WIDTH = 8,
   parameter int CYC_WIDTH  = 24,
   parameter int RST_CYCLES = 3,
   parameter int TIMEOUT    = 2**24-1
) (
   input wire logic                   clk,
   input wire logic                   rst,
   placement_run_sequencer_if.master  bus
);

   localparam int                   c_RCNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [c_RCNT_W-1:0]  c_RST_LAST = c_RCNT_W'(RST_CYCLES - 1);
   localparam logic [CYC_WIDTH-1:0] c_TIMEOUT  = CYC_WIDTH'(TIMEOUT);

   state_t                r_state;
   state_t                w_next;

   logic [c_RCNT_W-1:0]   r_rst_cnt;
   logic [CYC_WIDTH-1:0]  r_cyc;
   logic [RUNS_WIDTH-1:0] r_run;
   logic [RUNS_WIDTH-1:0] r_n_runs;
   logic [EDGE_WIDTH-1:0] r_n_edge;

   logic [RUNS_WIDTH-1:0] r_res_run;
   logic [SEED_WIDTH-1:0] r_res_seed;
   logic [COST_WIDTH-1:0] r_res_cost;
   logic [CYC_WIDTH-1:0]  r_res_cycles;
   logic                  r_res_timeout;

   logic [COST_WIDTH-1:0] r_best_cost;
   logic [SEED_WIDTH-1:0] r_best_seed;

   logic                  w_cfg_acc;
   logic                  w_run_end;
   logic                  w_res_acc;
   logic                  w_last_run;
   logic [SEED_WIDTH-1:0] w_seed;

   logic                  w_cfg_ready;
   logic                  w_pl_rst;
   logic                  w_pl_loadseed;
   logic                  w_pl_start;
   logic                  w_res_valid;
   logic                  w_finished;
   logic                  w_busy;

   assign w_cfg_acc  = (r_state == S_IDLE) && bus.cfg_valid;
   assign w_run_end  = (r_state == S_RUN) && (bus.pl_done || (r_cyc == c_TIMEOUT));
   assign w_res_acc  = (r_state == S_REPORT) && bus.res_ready;
   assign w_last_run = ((r_run + RUNS_WIDTH'(1)) == r_n_runs);

   placement_run_sequencer_seed_gen u_seed_gen (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_cfg_acc),
      .i_advance (w_res_acc && !w_last_run),
      .i_seed    (bus.cfg_seed),
      .o_seed    (w_seed)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_cfg_ready   = 1'b0;
      w_pl_rst      = 1'b0;
      w_pl_loadseed = 1'b0;
      w_pl_start    = 1'b0;
      w_res_valid   = 1'b0;
      w_finished    = 1'b0;
      w_busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_cfg_ready = 1'b1;
            w_pl_rst    = 1'b1;
            w_busy      = 1'b0;
            if (bus.cfg_valid) begin
               w_next = (bus.cfg_n_runs == '0) ? S_FINISH : S_RESET;
            end
         end
         S_RESET: begin
            w_pl_rst = 1'b1;
            if (r_rst_cnt == c_RST_LAST) begin
               w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_pl_loadseed = 1'b1;
            w_next        = S_RUN;
         end
         S_RUN: begin
            w_pl_start = 1'b1;
            if (w_run_end) begin
               w_next = S_REPORT;
            end
         end
         S_REPORT: begin
            w_res_valid = 1'b1;
            if (bus.res_ready) begin
               w_next = w_last_run ? S_FINISH : S_RESET;
            end
         end
         S_FINISH: begin
            w_finished = 1'b1;
            w_next     = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Counters read as zero on the first cycle of their state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rst_cnt <= '0;
         r_cyc     <= '0;
      end else begin
         r_rst_cnt <= (r_state == S_RESET) ? (r_rst_cnt + c_RCNT_W'(1)) : '0;
         r_cyc     <= (r_state == S_RUN) ? (r_cyc + CYC_WIDTH'(1)) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run         <= '0;
         r_n_runs      <= '0;
         r_n_edge      <= '0;
         r_res_run     <= '0;
         r_res_seed    <= '0;
         r_res_cost    <= '0;
         r_res_cycles  <= '0;
         r_res_timeout <= 1'b0;
         r_best_cost   <= '1;
         r_best_seed   <= '0;
      end else begin
         if (w_cfg_acc) begin
            r_n_edge    <= bus.cfg_n_edge;
            r_n_runs    <= bus.cfg_n_runs;
            r_run       <= '0;
            r_best_cost <= '1;
            r_best_seed <= '0;
         end
         if (w_run_end) begin
            r_res_run    <= r_run;
            r_res_seed   <= w_seed;
            r_res_cycles <= r_cyc;
            // A done arriving on the timeout cycle still wins.
            if (bus.pl_done) begin
               r_res_cost    <= bus.pl_cost;
               r_res_timeout <= 1'b0;
            end else begin
               r_res_cost    <= '1;
               r_res_timeout <= 1'b1;
            end
         end
         if (w_res_acc) begin
            r_run <= r_run + RUNS_WIDTH'(1);
            if (!r_res_timeout && (r_res_cost < r_best_cost)) begin
               r_best_cost <= r_res_cost;
               r_best_seed <= r_res_seed;
            end
         end
      end
   end

   assign bus.cfg_ready   = w_cfg_ready;
   assign bus.pl_rst      = w_pl_rst;
   assign bus.pl_loadseed = w_pl_loadseed;
   assign bus.pl_seed     = w_seed;
   assign bus.pl_start    = w_pl_start;
   assign bus.pl_n_edge   = r_n_edge;
   assign bus.res_valid   = w_res_valid;
   assign bus.res_run     = r_res_run;
   assign bus.res_seed    = r_res_seed;
   assign bus.res_cost    = r_res_cost;
   assign bus.res_cycles  = r_res_cycles;
   assign bus.res_timeout = r_res_timeout;
   assign bus.best_cost   = r_best_cost;
   assign bus.best_seed   = r_best_seed;
   assign bus.busy        = w_busy;
   assign bus.finished    = w_finished;

endmodule
`default_nettype wire
